// File: rtl/ej1_pkg.sv
// Shared constants for the ej1 datapath sequencer: datapath select codes, FSM states, default widths.
package ej1_pkg;

    localparam int DATA_W_DEF = 3;
    localparam int ACC_W_DEF  = 6;
    localparam int CNT_W_DEF  = 8;

    localparam logic [1:0] SEL_SUB  = 2'b00;
    localparam logic [1:0] SEL_ADD  = 2'b01;
    localparam logic [1:0] SEL_PASS = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/ej1_cycle_counter.sv
// Loadable down-counter for job length; saturates at zero, flags the final (count==1) cycle.
module ej1_cycle_counter
    import ej1_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_last,
    output logic             o_zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (i_en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign o_last = (count == CNT_W'(1));
    assign o_zero = (count == '0);

endmodule

// File: rtl/ej1_seq_ctrl.sv
// Job sequencer for the ej1 adder/accumulator datapath: clear, run N cycles, capture, pulse done.
// Optional early stop on overflow: define SEQ_STOP_ON_OVF_EN.
module ej1_seq_ctrl
    import ej1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [CNT_W-1:0]  i_n,
    output logic              o_busy,
    output logic              o_done,
    output logic [ACC_W-1:0]  o_result,
    output logic              o_ovf,
    output logic [CNT_W-1:0]  o_cycles,
    output logic [1:0]        o_dp_sel,
    output logic [DATA_W-1:0] o_dp_data1,
    output logic [DATA_W-1:0] o_dp_data2,
    output logic              o_dp_rst_n,
    input  logic [ACC_W-1:0]  i_dp_data,
    input  logic              i_dp_overflow
);

    seq_state_t state, state_nxt;
    logic       accept, run_step, capture, busy_nxt, dp_rst_n_nxt;
    logic       cnt_last, cnt_zero, ovf_stop;

    ej1_cycle_counter #(.CNT_W(CNT_W)) u_cycle_counter (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_load     (accept),
        .i_en       (run_step),
        .i_load_val (i_n),
        .o_last     (cnt_last),
        .o_zero     (cnt_zero)
    );

`ifdef SEQ_STOP_ON_OVF_EN
    assign ovf_stop = i_dp_overflow;
`else
    assign ovf_stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = cnt_zero ? ST_DONE : ST_RUN;
            ST_RUN:   if (cnt_last || ovf_stop) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The done pulse is registered out of DONE, so it lands in the first IDLE cycle;
    // a start seen alongside it must still be refused.
    always_comb begin
        accept       = (state == ST_IDLE) && i_start && !o_done;
        run_step     = (state == ST_RUN);
        capture      = (state == ST_DONE);
        busy_nxt     = (state_nxt != ST_IDLE);
        // Datapath stays enabled through DONE so the final accumulation is still visible when captured.
        dp_rst_n_nxt = (state_nxt == ST_RUN) || ((state_nxt == ST_DONE) && (state == ST_RUN));
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_result   <= '0;
            o_ovf      <= 1'b0;
            o_cycles   <= '0;
            o_dp_sel   <= SEL_ZERO;
            o_dp_data1 <= '0;
            o_dp_data2 <= '0;
            o_dp_rst_n <= 1'b0;
        end else begin
            o_busy     <= busy_nxt;
            o_done     <= capture;
            o_dp_rst_n <= dp_rst_n_nxt;
            if (accept) begin
                o_dp_sel   <= i_op;
                o_dp_data1 <= i_a;
                o_dp_data2 <= i_b;
                o_result   <= '0;
                o_ovf      <= 1'b0;
                o_cycles   <= '0;
            end
            if (run_step) begin
                o_cycles <= o_cycles + 1'b1;
                o_ovf    <= o_ovf | i_dp_overflow;
            end
            if (capture && (o_cycles != '0)) begin
                o_result <= i_dp_data;
                o_ovf    <= o_ovf | i_dp_overflow;
            end
        end
    end

endmodule

// File: tb/tb_ej1_seq_ctrl.sv
// Bench for ej1_seq_ctrl with a stand-in accumulator datapath and an arithmetic job reference model.
module tb_ej1_seq_ctrl;

    localparam int DATA_W = 3;
    localparam int ACC_W  = 6;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              i_rst_n;
    logic              i_start;
    logic [1:0]        i_op;
    logic [DATA_W-1:0] i_a, i_b;
    logic [CNT_W-1:0]  i_n;
    logic              o_busy, o_done, o_ovf, o_dp_rst_n;
    logic [ACC_W-1:0]  o_result;
    logic [CNT_W-1:0]  o_cycles;
    logic [1:0]        o_dp_sel;
    logic [DATA_W-1:0] o_dp_data1, o_dp_data2;
    logic [ACC_W-1:0]  dp_acc, dp_val;
    logic [ACC_W:0]    dp_sum;
    logic              dp_ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ej1_seq_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_op          (i_op),
        .i_a           (i_a),
        .i_b           (i_b),
        .i_n           (i_n),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_result      (o_result),
        .o_ovf         (o_ovf),
        .o_cycles      (o_cycles),
        .o_dp_sel      (o_dp_sel),
        .o_dp_data1    (o_dp_data1),
        .o_dp_data2    (o_dp_data2),
        .o_dp_rst_n    (o_dp_rst_n),
        .i_dp_data     (dp_acc),
        .i_dp_overflow (dp_ovf)
    );

    // Stand-in datapath: selective adder into a 6-bit accumulator with sticky carry-out.
    always_comb begin
        dp_val = '0;
        case (o_dp_sel)
            2'b00:   dp_val = ACC_W'(o_dp_data1) - ACC_W'(o_dp_data2);
            2'b01:   dp_val = ACC_W'(o_dp_data1) + ACC_W'(o_dp_data2);
            2'b10:   dp_val = ACC_W'(o_dp_data1);
            default: dp_val = '0;
        endcase
        dp_sum = {1'b0, dp_acc} + {1'b0, dp_val};
    end

    always_ff @(posedge clk or negedge o_dp_rst_n) begin
        if (!o_dp_rst_n) begin
            dp_acc <= '0;
            dp_ovf <= 1'b0;
        end else begin
            dp_acc <= dp_sum[ACC_W-1:0];
            dp_ovf <= dp_ovf | dp_sum[ACC_W];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int job_val(input int op, input int a, input int b);
        case (op)
            0:       return (a - b + 64) % 64;
            1:       return a + b;
            2:       return a;
            default: return 0;
        endcase
    endfunction

    // Whole-job outcome: total = cycles*val, result wraps mod 64, overflow iff total reached 64.
    task automatic ref_job(input int op, input int a, input int b, input int n,
                           output int res, output int ovf, output int cyc);
        int v;
        v   = job_val(op, a, b);
        cyc = n;
`ifdef SEQ_STOP_ON_OVF_EN
        for (int m = 1; m < n; m++) begin
            if (m * v >= 64) begin
                cyc = m + 1;
                break;
            end
        end
`endif
        res = (cyc * v) % 64;
        ovf = (cyc * v >= 64) ? 1 : 0;
    endtask

    task automatic run_job(input int op, input int a, input int b, input int n, input bit poke_busy);
        int  res, ovf, cyc, lat;
        bit  seen;
        ref_job(op, a, b, n, res, ovf, cyc);
        @(negedge clk);
        i_start = 1'b1;
        i_op    = 2'(op);
        i_a     = 3'(a);
        i_b     = 3'(b);
        i_n     = 8'(n);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_op    = 2'($urandom);
        i_a     = 3'($urandom);
        i_b     = 3'($urandom);
        i_n     = 8'($urandom);
        check("busy_after_accept", 32'(o_busy), 32'd1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 400) begin
            @(posedge clk);
            lat++;
            #1;
            if (poke_busy && lat == 3) begin
                i_start = 1'b1;
                i_a     = 3'd7;
            end
            if (poke_busy && lat == 4) i_start = 1'b0;
            if (o_done) seen = 1'b1;
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(lat), 32'(2 + cyc));
            check("result", 32'(o_result), 32'(res));
            check("ovf", 32'(o_ovf), 32'(ovf));
            check("cycles", 32'(o_cycles), 32'(cyc));
            check("busy_at_done", 32'(o_busy), 32'd0);
            i_start = 1'b1;
            @(posedge clk);
            #1;
            i_start = 1'b0;
            check("done_one_cycle", 32'(o_done), 32'd0);
            check("start_in_done_ignored", 32'(o_busy), 32'd0);
            check("result_held", 32'(o_result), 32'(res));
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b1;
        i_op    = 2'b01;
        i_a     = 3'd5;
        i_b     = 3'd2;
        i_n     = 8'd9;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_result", 32'(o_result), 32'd0);
        check("rst_ovf", 32'(o_ovf), 32'd0);
        check("rst_cycles", 32'(o_cycles), 32'd0);
        check("rst_dp_sel", 32'(o_dp_sel), 32'd3);
        check("rst_dp_data", 32'({o_dp_data1, o_dp_data2}), 32'd0);
        check("rst_dp_rst_n", 32'(o_dp_rst_n), 32'd0);
        @(negedge clk);
        i_start = 1'b0;
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_rst", 32'(o_busy), 32'd0);

        run_job(1, 1, 1, 10, 1'b0);
        run_job(1, 1, 1, 40, 1'b0);
        run_job(2, 5, 0, 0, 1'b0);
        run_job(2, 3, 0, 4, 1'b1);
        run_job(3, 0, 0, 255, 1'b0);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        i_start = 1'b1;
        i_op    = 2'b01;
        i_a     = 3'd3;
        i_b     = 3'd2;
        i_n     = 8'd20;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_cycles", 32'(o_cycles), 32'd0);
        check("midrst_dp_rst_n", 32'(o_dp_rst_n), 32'd0);
        check("midrst_dp_sel", 32'(o_dp_sel), 32'd3);
        @(negedge clk);
        i_rst_n = 1'b1;
        run_job(1, 1, 1, 10, 1'b0);

        for (int j = 0; j < 25; j++) begin
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 70)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
